// File: rtl/buffer_fifo.sv
// DEPTH-entry FIFO between two four-phase ready/done handshakes, with occupancy
// status and synchronous flush.
//
// state     | meaning
// IN_IDLE   | waiting for producer ready_in; done_in low
// IN_ACK    | word accepted, done_in high until producer drops ready_in
// OUT_IDLE  | nothing on offer; ready_out low
// OUT_OFFER | head word on data_out, ready_out high until consumer done_out
module buffer_fifo #(
  parameter int DATA_BITWIDTH = 8,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_BITWIDTH-1:0]   data_in,
  input  logic                       ready_in,
  output logic                       done_in,
  output logic [DATA_BITWIDTH-1:0]   data_out,
  output logic                       ready_out,
  input  logic                       done_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_OFFER} out_state_t;

  in_state_t  in_state, in_state_nxt;
  out_state_t out_state, out_state_nxt;

  logic [DATA_BITWIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic                     push, pop, offer;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign done_in   = (in_state == IN_ACK);
  assign ready_out = (out_state == OUT_OFFER);

  // A full FIFO may still accept a word on the same edge that the head is popped.
  always_comb begin
    pop   = (out_state == OUT_OFFER) && done_out && !flush;
    push  = (in_state == IN_IDLE) && ready_in && !flush && (!full || pop);
    offer = (out_state == OUT_IDLE) && !empty && !done_out && !flush;

    in_state_nxt = in_state;
    case (in_state)
      IN_IDLE: if (push)      in_state_nxt = IN_ACK;
      IN_ACK:  if (!ready_in) in_state_nxt = IN_IDLE;
      default:                in_state_nxt = IN_IDLE;
    endcase

    out_state_nxt = out_state;
    if (flush) begin
      out_state_nxt = OUT_IDLE;
    end else begin
      case (out_state)
        OUT_IDLE:  if (offer)    out_state_nxt = OUT_OFFER;
        OUT_OFFER: if (done_out) out_state_nxt = OUT_IDLE;
        default:                 out_state_nxt = OUT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state  <= IN_IDLE;
      out_state <= OUT_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      data_out  <= '0;
    end else begin
      in_state  <= in_state_nxt;
      out_state <= out_state_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
      end
      if (offer) data_out <= mem[rd_ptr];
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_buffer_fifo.sv
// Directed bench for buffer_fifo: stimulus pushes expected words into a scoreboard,
// a negedge monitor checks each new offer against it.
module tb_buffer_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst, flush, ready_in, done_out;
  logic [DW-1:0] data_in;
  logic          done_in, ready_out, full, empty;
  logic [DW-1:0] data_out;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];
  logic prev_ro = 1'b0;

  buffer_fifo #(.DATA_BITWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .ready_in(ready_in),
    .done_in(done_in), .data_out(data_out), .ready_out(ready_out), .done_out(done_out),
    .full(full), .empty(empty), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every fresh offer must carry the oldest outstanding word.
  always @(negedge clk) begin
    if (ready_out && !prev_ro) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_offer: got data %0h expected no offer at %0t", data_out, $time);
      end else begin
        logic [DW-1:0] exp_d;
        exp_d = sb.pop_front();
        if (data_out !== exp_d) begin
          errors++;
          $display("FAIL offer_data: got %0h expected %0h at %0t", data_out, exp_d, $time);
        end
      end
    end
    prev_ro = ready_out;
  end

  task automatic push_word(input logic [DW-1:0] d);
    int n;
    n = 0;
    data_in  = d;
    ready_in = 1'b1;
    do begin
      tick();
      n++;
    end while (!done_in && n < 20);
    check("push_ack", int'(done_in), 1);
    if (done_in) sb.push_back(d);
    ready_in = 1'b0;
    tick();
  endtask

  task automatic pop_word();
    int n;
    n = 0;
    while (!ready_out && n < 20) begin
      tick();
      n++;
    end
    check("offer_seen", int'(ready_out), 1);
    done_out = 1'b1;
    tick();
    check("offer_drop", int'(ready_out), 0);
    done_out = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done_in"},   int'(done_in),   0);
    check({tag, "_ready_out"}, int'(ready_out), 0);
    check({tag, "_data_out"},  int'(data_out),  0);
    check({tag, "_level"},     int'(level),     0);
    check({tag, "_empty"},     int'(empty),     1);
    check({tag, "_full"},      int'(full),      0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ready_in = 1'b0; done_out = 1'b0; data_in = '0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // 1: single word latency
    data_in = 8'hA5; ready_in = 1'b1;
    tick();
    check("t1_done_in", int'(done_in), 1);
    check("t1_level", int'(level), 1);
    check("t1_ready_out_early", int'(ready_out), 0);
    sb.push_back(8'hA5);
    tick();
    check("t1_ready_out", int'(ready_out), 1);
    check("t1_data_out", int'(data_out), 8'hA5);
    ready_in = 1'b0;
    done_out = 1'b1;
    tick();
    check("t1_ready_drop", int'(ready_out), 0);
    check("t1_level_end", int'(level), 0);
    check("t1_done_in_end", int'(done_in), 0);
    done_out = 1'b0;
    tick();

    // 2: fill, backpressure, then release
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    check("t2_level", int'(level), 4);
    check("t2_full", int'(full), 1);
    data_in = 8'h05; ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_backpressure", int'(done_in), 0);
    end
    check("t2_level_hold", int'(level), 4);
    done_out = 1'b1;
    tick();
    check("t2_fifth_ack", int'(done_in), 1);
    check("t2_level_swap", int'(level), 4);
    sb.push_back(8'h05);
    ready_in = 1'b0; done_out = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) pop_word();
    check("t2_level_end", int'(level), 0);
    check("t2_empty_end", int'(empty), 1);

    // 3: interleaved push/pop across pointer wrap
    push_word(8'h10);
    push_word(8'h11);
    for (int i = 0; i < 10; i++) begin
      push_word(8'(8'h12 + i));
      check("t3_level_hi", int'(level), 3);
      pop_word();
      check("t3_level_lo", int'(level), 2);
    end
    pop_word();
    pop_word();
    check("t3_level_end", int'(level), 0);

    // 4: simultaneous push and pop while full
    for (int i = 0; i < 4; i++) push_word(8'(8'hA0 + i));
    check("t4_full", int'(full), 1);
    data_in = 8'hA4; ready_in = 1'b1; done_out = 1'b1;
    tick();
    check("t4_level", int'(level), 4);
    check("t4_done_in", int'(done_in), 1);
    check("t4_ready_out", int'(ready_out), 0);
    sb.push_back(8'hA4);
    ready_in = 1'b0; done_out = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) pop_word();
    check("t4_level_end", int'(level), 0);

    // 5: flush with a write request pending
    push_word(8'hB0);
    push_word(8'hB1);
    push_word(8'hB2);
    check("t5_level", int'(level), 3);
    check("t5_ready_out", int'(ready_out), 1);
    flush = 1'b1; data_in = 8'hC0; ready_in = 1'b1;
    sb.delete();
    tick();
    check("t5_level_flush", int'(level), 0);
    check("t5_ready_flush", int'(ready_out), 0);
    check("t5_empty_flush", int'(empty), 1);
    check("t5_done_in_flush", int'(done_in), 0);
    flush = 1'b0;
    tick();
    check("t5_retry_ack", int'(done_in), 1);
    check("t5_level_retry", int'(level), 1);
    sb.push_back(8'hC0);
    ready_in = 1'b0;
    tick();
    pop_word();
    check("t5_level_end", int'(level), 0);

    // 6: reset in mid-handshake on both sides
    data_in = 8'hD0; ready_in = 1'b1;
    tick();
    sb.push_back(8'hD0);
    tick();
    check("t6_pre_done_in", int'(done_in), 1);
    check("t6_pre_ready_out", int'(ready_out), 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("t6");
    rst = 1'b0; ready_in = 1'b0;
    tick();
    tick();
    check("t6_sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
